// File: rtl/RS5_pkg.sv
// Shared types and register map for the RS5 bus peripherals.
package RS5_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_DIV    = 4'h8;
    localparam logic [3:0] UART_CTRL   = 4'hC;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous pointer-plus-count FIFO; the head entry is always visible on rdata_o.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, bit timer and frame FSM.
module uart_tx
    import RS5_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [3:0]  we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] div_q, div_d;
    logic        txen_q, txen_d;
    logic        ie_q, ie_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]      reg_addr;
    logic            wr_en, rd_en;
    logic            fifo_push, fifo_pop;
    logic [7:0]      fifo_rdata;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            bit_done;
    logic [31:0]     status_word;
    logic            unused_bits;

    assign reg_addr  = {addr_i[3:2], 2'b00};
    assign wr_en     = en_i & (|we_i);
    assign rd_en     = en_i & ~(|we_i);
    assign fifo_push = wr_en & (reg_addr == UART_TXDATA);
    assign unused_bits = ^{addr_i[1:0], data_i[31:16]};

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (data_i[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Every bit reloads from div_q, so a DIV write lands on the next bit boundary.
    assign bit_done = (bit_cnt_q <= 16'd1);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        fifo_pop  = 1'b0;
        tx_o      = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (txen_q && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    bit_cnt_d = div_q;
                    state_d   = START;
                end
            end
            START: begin
                tx_o = 1'b0;
                if (bit_done) begin
                    bit_cnt_d = div_q;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            DATA: begin
                tx_o = shift_q[0];
                if (bit_done) begin
                    bit_cnt_d = div_q;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign status_word = {16'h0000, 8'(fifo_count), 4'h0,
                          ovf_q, fifo_empty, fifo_full, (state_q != IDLE)};

    always_comb begin
        div_d   = div_q;
        txen_d  = txen_q;
        ie_d    = ie_q;
        ovf_d   = ovf_q;
        rdata_d = rdata_q;
        if (fifo_push && fifo_full) begin
            ovf_d = 1'b1;
        end
        if (wr_en) begin
            case (reg_addr)
                UART_STATUS: if (data_i[3]) ovf_d = 1'b0;
                UART_DIV:    div_d = (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
                UART_CTRL: begin
                    txen_d = data_i[0];
                    ie_d   = data_i[1];
                end
                default: ;
            endcase
        end
        if (rd_en) begin
            case (reg_addr)
                UART_STATUS: rdata_d = status_word;
                UART_DIV:    rdata_d = {16'h0000, div_q};
                UART_CTRL:   rdata_d = {30'h0, ie_q, txen_q};
                default:     rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 16'd0;
            bit_idx_q <= 3'd0;
            div_q     <= DIV_RESET;
            txen_q    <= 1'b0;
            ie_q      <= 1'b0;
            ovf_q     <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            div_q     <= div_d;
            txen_q    <= txen_d;
            ie_q      <= ie_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
        end
    end

    assign data_o = rdata_q;
    assign irq_o  = ie_q & fifo_empty & (state_q == IDLE);

endmodule
